sha256_msg_sched_ctrl: RTL and testbench



---
 rtl/sha256_pkg.sv | 26 ++
 rtl/sha256_w_expand.sv | 15 +
 rtl/sha256_msg_sched_ctrl.sv | 145 ++++++++++++++
 tb/tb_sha256_msg_sched_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word type, block/round sizes, schedule FSM
// states and the small sigma functions that both the message schedule
// and the round engine use.
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam int SHA256_ROUNDS    = 64;
  localparam int SHA256_BLK_WORDS = 16;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_e;

  // sig0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic word_t sig0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // sig1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic word_t sig1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b00_0000_0000, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// Message-schedule expansion: W(t) from the four circular-buffer taps
// W(t-2), W(t-7), W(t-15), W(t-16). Purely combinational, modulo 2^32.
module sha256_w_expand
  import sha256_pkg::*;
(
  input  word_t i_w2,
  input  word_t i_w7,
  input  word_t i_w15,
  input  word_t i_w16,
  output word_t o_wt
);

  assign o_wt = sig1(i_w2) + i_w7 + sig0(i_w15) + i_w16;

endmodule

// File: rtl/sha256_msg_sched_ctrl.sv
// SHA-256 message schedule controller: loads 16 message words into a
// circular buffer, then streams W0..W63 to the round engine, expanding
// W16..W63 in place so the buffer always holds the last 16 words.
module sha256_msg_sched_ctrl
  import sha256_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        abort_i,
  input  logic        m_v_i,
  input  logic [31:0] m_i,
  output logic        m_ready_o,
  output logic        wt_v_o,
  output logic [31:0] wt_o,
  output logic [5:0]  t_o,
  input  logic        wt_ready_i,
  output logic        last_o
);

  sched_state_e r_state;
  sched_state_e w_state_nxt;
  logic [3:0]   r_lcnt;
  logic [3:0]   w_lcnt_nxt;
  logic [5:0]   r_t;
  logic [5:0]   w_t_nxt;
  word_t        r_buf [SHA256_BLK_WORDS];

  logic         w_buf_we;
  logic [3:0]   w_buf_waddr;
  word_t        w_buf_wdata;

  logic [3:0]   w_idx;
  logic [3:0]   w_idx2;
  logic [3:0]   w_idx7;
  logic [3:0]   w_idx15;
  word_t        w_expand;
  word_t        w_wt;
  logic         w_expanding;

  // Tap addresses wrap in 4 bits; W(t-16) lives where W(t) will be written.
  assign w_idx       = r_t[3:0];
  assign w_idx2      = w_idx - 4'd2;
  assign w_idx7      = w_idx - 4'd7;
  assign w_idx15     = w_idx - 4'd15;
  assign w_expanding = (r_t[5:4] != 2'b00);

  sha256_w_expand u_w_expand (
    .i_w2  (r_buf[w_idx2]),
    .i_w7  (r_buf[w_idx7]),
    .i_w15 (r_buf[w_idx15]),
    .i_w16 (r_buf[w_idx]),
    .o_wt  (w_expand)
  );

  assign w_wt = w_expanding ? w_expand : r_buf[w_idx];

  assign m_ready_o = (r_state == ST_LOAD);
  assign wt_v_o    = (r_state == ST_RUN);
  assign wt_o      = w_wt;
  assign t_o       = r_t;
  assign last_o    = (r_state == ST_RUN) && (r_t == 6'd63);

  // Next-state, counter and buffer-write decode; abort overrides handshakes.
  always_comb begin
    w_state_nxt = r_state;
    w_lcnt_nxt  = r_lcnt;
    w_t_nxt     = r_t;
    w_buf_we    = 1'b0;
    w_buf_waddr = r_lcnt;
    w_buf_wdata = m_i;
    if (abort_i) begin
      w_state_nxt = ST_LOAD;
      w_lcnt_nxt  = 4'd0;
      w_t_nxt     = 6'd0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (m_v_i) begin
            w_buf_we    = 1'b1;
            w_buf_waddr = r_lcnt;
            w_buf_wdata = m_i;
            if (r_lcnt == 4'd15) begin
              w_state_nxt = ST_RUN;
              w_lcnt_nxt  = 4'd0;
              w_t_nxt     = 6'd0;
            end else begin
              w_lcnt_nxt  = r_lcnt + 4'd1;
            end
          end else begin
            w_lcnt_nxt = r_lcnt;
          end
        end
        ST_RUN: begin
          if (wt_ready_i) begin
            if (w_expanding) begin
              w_buf_we    = 1'b1;
              w_buf_waddr = w_idx;
              w_buf_wdata = w_expand;
            end else begin
              w_buf_we    = 1'b0;
            end
            if (r_t == 6'd63) begin
              w_state_nxt = ST_LOAD;
              w_t_nxt     = 6'd0;
            end else begin
              w_t_nxt     = r_t + 6'd1;
            end
          end else begin
            w_t_nxt = r_t;
          end
        end
        default: begin
          w_state_nxt = ST_LOAD;
          w_lcnt_nxt  = 4'd0;
          w_t_nxt     = 6'd0;
        end
      endcase
    end
  end

  // FSM state and round/load counters.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_LOAD;
      r_lcnt  <= 4'd0;
      r_t     <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_lcnt  <= w_lcnt_nxt;
      r_t     <= w_t_nxt;
    end
  end

  // Circular W buffer: message words during load, expanded words during run.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < SHA256_BLK_WORDS; i++) begin
        r_buf[i] <= 32'h0000_0000;
      end
    end else if (w_buf_we) begin
      r_buf[w_buf_waddr] <= w_buf_wdata;
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched_ctrl.sv
// Self-checking bench for sha256_msg_sched_ctrl: random blocks, stalls,
// gapped loads, abort, mid-run reset and back-to-back throughput checked
// against a full-array SHA-256 schedule model.
module tb_sha256_msg_sched_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        m_v_i = 1'b0;
  logic [31:0] m_i = 32'h0;
  logic        m_ready_o;
  logic        wt_v_o;
  logic [31:0] wt_o;
  logic [5:0]  t_o;
  logic        wt_ready_i = 1'b0;
  logic        last_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] cur_m [16];
  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];
  logic [31:0] bbm   [2][16];
  logic [31:0] bbexp [2][64];

  sha256_msg_sched_ctrl dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .abort_i    (abort_i),
    .m_v_i      (m_v_i),
    .m_i        (m_i),
    .m_ready_o  (m_ready_o),
    .wt_v_o     (wt_v_o),
    .wt_o       (wt_o),
    .t_o        (t_o),
    .wt_ready_i (wt_ready_i),
    .last_o     (last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule over the full 64-entry array.
  task automatic model_sched();
    logic [31:0] s0, s1;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp_w[t] = cur_m[t];
      else begin
        s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
        s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
        exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
      end
    end
  endtask

  task automatic rand_block();
    for (int i = 0; i < 16; i++) cur_m[i] = $urandom;
    model_sched();
  endtask

  // Drive one cycle's inputs at the falling edge, return at the next one.
  task automatic cyc(input logic mv, input logic [31:0] m, input logic rdy, input logic ab);
    m_v_i = mv; m_i = m; wt_ready_i = rdy; abort_i = ab;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic load_block(input bit gapped);
    int k = 0;
    int guard = 0;
    while (k < 16 && guard < 200) begin
      guard++;
      check_eq("load_mready", {31'd0, m_ready_o}, 32'd1);
      check_eq("load_wtv", {31'd0, wt_v_o}, 32'd0);
      if (gapped && $urandom_range(0, 1) == 1) cyc(1'b0, $urandom, 1'b1, 1'b0);
      else begin
        cyc(1'b1, cur_m[k], 1'b0, 1'b0);
        k++;
      end
    end
    check_eq("load_timeout", k, 32'd16);
    check_eq("lat_wtv", {31'd0, wt_v_o}, 32'd1);
    check_eq("lat_t0", {26'd0, t_o}, 32'd0);
    check_eq("lat_w0", wt_o, cur_m[0]);
  endtask

  task automatic run_block(input int rdy_pct, input int abort_at, input int reset_at);
    int t = 0;
    int guard = 0;
    logic rdy;
    while (t < 64 && guard < 2000) begin
      guard++;
      check_eq("run_wtv", {31'd0, wt_v_o}, 32'd1);
      check_eq("run_mready", {31'd0, m_ready_o}, 32'd0);
      check_eq("run_t", {26'd0, t_o}, t);
      check_eq("run_wt", wt_o, exp_w[t]);
      check_eq("run_last", {31'd0, last_o}, (t == 63) ? 32'd1 : 32'd0);
      if (t == reset_at) begin
        #2 reset_n_i = 1'b0;
        #1;
        check_eq("rst_wtv", {31'd0, wt_v_o}, 32'd0);
        check_eq("rst_mready", {31'd0, m_ready_o}, 32'd1);
        check_eq("rst_t", {26'd0, t_o}, 32'd0);
        check_eq("rst_wt", wt_o, 32'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        check_eq("rst_wtv_after", {31'd0, wt_v_o}, 32'd0);
        check_eq("rst_t_after", {26'd0, t_o}, 32'd0);
        return;
      end
      if (t == abort_at) begin
        cyc(1'b1, $urandom, 1'b1, 1'b1);
        abort_i = 1'b0;
        check_eq("abort_mready", {31'd0, m_ready_o}, 32'd1);
        check_eq("abort_wtv", {31'd0, wt_v_o}, 32'd0);
        check_eq("abort_t", {26'd0, t_o}, 32'd0);
        return;
      end
      rdy = ($urandom_range(0, 99) < rdy_pct);
      if (rdy) got_w[t] = wt_o;
      cyc(1'b0, 32'd0, rdy, 1'b0);
      if (rdy) t++;
    end
    check_eq("run_timeout", t, 32'd64);
    check_eq("turn_mready", {31'd0, m_ready_o}, 32'd1);
    check_eq("turn_wtv", {31'd0, wt_v_o}, 32'd0);
    check_eq("turn_last", {31'd0, last_o}, 32'd0);
  endtask

  initial begin
    int start_cyc [2];
    int bi_in, li, bo, to, cyc_n;
    logic mv, hs_in, hs_out;
    logic [31:0] mw;

    // Reset state
    #1;
    check_eq("reset_mready", {31'd0, m_ready_o}, 32'd1);
    check_eq("reset_wtv", {31'd0, wt_v_o}, 32'd0);
    check_eq("reset_t", {26'd0, t_o}, 32'd0);
    check_eq("reset_last", {31'd0, last_o}, 32'd0);
    check_eq("reset_wt", wt_o, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);

    // "abc" block, no stalls
    for (int i = 0; i < 16; i++) cur_m[i] = 32'h0;
    cur_m[0]  = 32'h6162_6380;
    cur_m[15] = 32'h0000_0018;
    model_sched();
    load_block(1'b0);
    run_block(100, -1, -1);
    check_eq("abc_W0",  got_w[0],  32'h6162_6380);
    check_eq("abc_W15", got_w[15], 32'h0000_0018);
    check_eq("abc_W16", got_w[16], 32'h6162_6380);
    check_eq("abc_W17", got_w[17], 32'h000F_0000);

    // Same block with 50% backpressure must yield identical words
    load_block(1'b0);
    run_block(50, -1, -1);

    // Random blocks, gapped loads, random stalls
    for (int b = 0; b < 3; b++) begin
      rand_block();
      load_block(1'b1);
      run_block(50, -1, -1);
    end

    // Abort at t=40 with a same-cycle handshake, then a fresh block
    rand_block();
    load_block(1'b0);
    run_block(100, 40, -1);
    rand_block();
    load_block(1'b0);
    run_block(100, -1, -1);

    // Asynchronous reset mid-run at t=30, then a fresh block
    rand_block();
    load_block(1'b0);
    run_block(100, -1, 30);
    rand_block();
    load_block(1'b1);
    run_block(70, -1, -1);

    // Back-to-back blocks with m_v_i held high: 80-cycle period
    for (int b = 0; b < 2; b++) begin
      rand_block();
      for (int i = 0; i < 16; i++) bbm[b][i] = cur_m[i];
      for (int i = 0; i < 64; i++) bbexp[b][i] = exp_w[i];
    end
    bi_in = 0; li = 0; bo = 0; to = 0; cyc_n = 0;
    start_cyc[0] = 0; start_cyc[1] = 0;
    while (bo < 2 && cyc_n < 400) begin
      if (wt_v_o) begin
        check_eq("bb_t", {26'd0, t_o}, to);
        check_eq("bb_wt", wt_o, bbexp[bo][to]);
      end
      mv = 1'b1;
      mw = 32'hDEAD_BEEF;
      if (m_ready_o && bi_in < 2) begin
        mw = bbm[bi_in][li];
        if (li == 0) start_cyc[bi_in] = cyc_n;
      end
      hs_in  = mv & m_ready_o;
      hs_out = wt_v_o;
      cyc(mv, mw, 1'b1, 1'b0);
      cyc_n++;
      if (hs_in && bi_in < 2) begin
        li++;
        if (li == 16) begin li = 0; bi_in++; end
      end
      if (hs_out) begin
        to++;
        if (to == 64) begin to = 0; bo++; end
      end
    end
    check_eq("bb_timeout", bo, 32'd2);
    check_eq("bb_period", start_cyc[1] - start_cyc[0], 32'd80);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
